// File: rtl/glip_dii_pkg.sv
// Shared types and constants for the GLIP debug-interconnect ingress block.
package glip_dii_pkg;

    // Width of the forwarded/discarded packet statistics counters.
    localparam int CNT_W = 16;

    // Packet framing states: waiting for a length word, forwarding payload,
    // or swallowing the payload of a rejected packet.
    typedef enum logic [1:0] {
        HDR  = 2'd0,
        FWD  = 2'd1,
        DROP = 2'd2
    } state_t;

endpackage

// File: rtl/glip_skid_buffer.sv
// Two-entry output skid buffer holding {last, data}. Ready and valid come
// straight from flops so nothing combinational crosses from the downstream
// ready back to the upstream side.
module glip_skid_buffer #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_last,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready
);

    logic [WIDTH-1:0] mem_data [2];
    logic             mem_last [2];
    logic             wr_ptr;
    logic             rd_ptr;
    logic [1:0]       count;
    logic [1:0]       count_next;
    logic             ready_q;
    logic             valid_q;
    logic             push;
    logic             pop;

    assign push      = in_valid && ready_q;
    assign pop       = valid_q && out_ready;
    assign in_ready  = ready_q;
    assign out_valid = valid_q;
    assign out_data  = mem_data[rd_ptr];
    assign out_last  = mem_last[rd_ptr];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        count_next = count;
        if (push && !pop) begin
            count_next = count + 2'd1;
        end else if (pop && !push) begin
            count_next = count - 2'd1;
        end
    end

    // Storage, pointers and the registered ready/valid flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_data[0] <= '0;
            mem_data[1] <= '0;
            mem_last[0] <= 1'b0;
            mem_last[1] <= 1'b0;
            wr_ptr      <= 1'b0;
            rd_ptr      <= 1'b0;
            count       <= 2'd0;
            ready_q     <= 1'b1;
            valid_q     <= 1'b0;
        end else begin
            if (push) begin
                mem_data[wr_ptr] <= in_data;
                mem_last[wr_ptr] <= in_last;
                wr_ptr           <= ~wr_ptr;
            end
            if (pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count   <= count_next;
            ready_q <= (count_next != 2'd2);
            valid_q <= (count_next != 2'd0);
        end
    end

endmodule

// File: rtl/glip_dii_ingress.sv
// Rebuilds length-prefixed debug packets from the GLIP host-to-device word
// stream. Zero-length and oversize packets are consumed and discarded.
// Handshakes: a word moves on any cycle where valid and ready are both high,
// on the input side and on the output side alike.
module glip_dii_ingress
    import glip_dii_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int MAX_LEN = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             drop_pulse,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] drop_count
);

    localparam logic [WIDTH-1:0] MAX_LEN_W = WIDTH'(MAX_LEN);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] remaining;
    logic [WIDTH-1:0] remaining_next;
    logic             ready_en;
    logic             accept;
    logic             push;
    logic             push_last;
    logic             pkt_inc;
    logic             drop_evt;
    logic             skid_ready;

    // in_ready depends only on flops: stays low in reset, rises one edge later.
    assign in_ready = ready_en && ((state != FWD) || skid_ready);
    assign accept   = in_valid && in_ready;

    // Holds input ready low until the first clock after reset release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Framing FSM state and payload countdown registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= HDR;
            remaining <= '0;
        end else begin
            state     <= state_next;
            remaining <= remaining_next;
        end
    end

    // Next-state logic: decode the length word, then forward or swallow.
    always_comb begin
        state_next     = state;
        remaining_next = remaining;
        push           = 1'b0;
        push_last      = 1'b0;
        pkt_inc        = 1'b0;
        drop_evt       = 1'b0;
        case (state)
            HDR: begin
                if (accept) begin
                    if (in_data == '0) begin
                        drop_evt = 1'b1;
                    end else if (in_data > MAX_LEN_W) begin
                        remaining_next = in_data;
                        drop_evt       = 1'b1;
                        state_next     = DROP;
                    end else begin
                        remaining_next = in_data;
                        state_next     = FWD;
                    end
                end
            end
            FWD: begin
                push      = accept;
                push_last = (remaining == ONE_W);
                if (accept) begin
                    remaining_next = remaining - ONE_W;
                    if (remaining == ONE_W) begin
                        pkt_inc    = 1'b1;
                        state_next = HDR;
                    end
                end
            end
            DROP: begin
                if (accept) begin
                    remaining_next = remaining - ONE_W;
                    if (remaining == ONE_W) begin
                        state_next = HDR;
                    end
                end
            end
            default: begin
                state_next = HDR;
            end
        endcase
    end

    // Statistics: forwarded count wraps, dropped count saturates.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pkt_count  <= '0;
            drop_count <= '0;
            drop_pulse <= 1'b0;
        end else begin
            drop_pulse <= drop_evt;
            if (pkt_inc) begin
                pkt_count <= pkt_count + CNT_W'(1);
            end
            if (drop_evt && (drop_count != '1)) begin
                drop_count <= drop_count + CNT_W'(1);
            end
        end
    end

    glip_skid_buffer #(
        .WIDTH(WIDTH)
    ) u_skid (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_last  (push_last),
        .in_valid (push),
        .in_ready (skid_ready),
        .out_data (out_data),
        .out_last (out_last),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

endmodule

// File: tb/tb_glip_dii_ingress.sv
// Directed bench for glip_dii_ingress: reset values, latency, backpressure,
// oversize/zero-length discard, random back-to-back traffic, mid-packet reset.
module tb_glip_dii_ingress;

    localparam int W = 16;

    logic          clk;
    logic          rst;
    logic [W-1:0]  in_data;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  out_data;
    logic          out_last;
    logic          out_valid;
    logic          out_ready;
    logic          drop_pulse;
    logic [15:0]   pkt_count;
    logic [15:0]   drop_count;

    int n_tests = 0;
    int n_fail  = 0;
    int drop_seen = 0;
    int exp_pkt = 0;
    int exp_drop = 0;
    logic rand_rdy = 1'b0;

    // {last, data}
    logic [W:0] exp_q[$];

    glip_dii_ingress #(.WIDTH(W), .MAX_LEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_pulse(drop_pulse),
        .pkt_count (pkt_count),
        .drop_count(drop_count)
    );

    // Clock and watchdog.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Scoreboard: every output transfer is compared with the expected queue.
    always @(negedge clk) begin
        if (rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_flit: got last=%0b data=0x%0h, none expected", out_last, out_data);
            end else begin
                check("flit", {15'd0, out_last, out_data}, {15'd0, exp_q.pop_front()});
            end
        end
        if (drop_pulse) drop_seen++;
    end

    // Random downstream backpressure while enabled.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Drives one word and waits until it is accepted (bounded).
    task automatic send_word(input logic [W-1:0] w);
        int cyc;
        cyc = 0;
        in_data  = w;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            cyc++;
            if (cyc > 1000) begin
                n_tests++;
                n_fail++;
                $display("FAIL send_timeout: word 0x%0h not accepted, in_ready stuck at %0b", w, in_ready);
                break;
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic wait_drain();
        int cyc;
        cyc = 0;
        while (exp_q.size() != 0 && cyc < 2000) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("drain", exp_q.size(), 0);
        idle(3);
    endtask

    initial begin
        logic [W-1:0] w;
        int len;

        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b1;

        // Reset values.
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_last", out_last, 0);
        check("rst_drop_pulse", drop_pulse, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("in_ready_after_rst", in_ready, 1);

        // Single packet with one-cycle latency.
        send_word(16'h0003);
        check("hdr_not_forwarded", out_valid, 0);
        exp_q.push_back({1'b0, 16'h00A1});
        exp_q.push_back({1'b0, 16'h00B2});
        exp_q.push_back({1'b1, 16'h00C3});
        send_word(16'h00A1);
        check("lat_a_valid", out_valid, 1);
        check("lat_a_data", out_data, 16'h00A1);
        check("lat_a_last", out_last, 0);
        send_word(16'h00B2);
        check("lat_b_data", out_data, 16'h00B2);
        send_word(16'h00C3);
        check("lat_c_data", out_data, 16'h00C3);
        check("lat_c_last", out_last, 1);
        check("single_pkt_count", pkt_count, 1);
        wait_drain();

        // Backpressure: downstream stalls mid-packet.
        out_ready = 1'b0;
        send_word(16'h0004);
        exp_q.push_back({1'b0, 16'h1111});
        exp_q.push_back({1'b0, 16'h2222});
        exp_q.push_back({1'b0, 16'h3333});
        exp_q.push_back({1'b1, 16'h4444});
        send_word(16'h1111);
        send_word(16'h2222);
        check("bp_in_ready_full", in_ready, 0);
        check("bp_out_data_hold", out_data, 16'h1111);
        fork
            send_word(16'h3333);
            begin
                repeat (3) begin
                    @(posedge clk);
                    #1;
                end
                check("bp_stable_data", out_data, 16'h1111);
                check("bp_stable_last", out_last, 0);
                check("bp_pkt_not_yet", pkt_count, 1);
                out_ready = 1'b1;
            end
        join
        send_word(16'h4444);
        wait_drain();
        check("bp_pkt_count", pkt_count, 2);

        // Oversize packet is swallowed.
        drop_seen = 0;
        send_word(16'h0021);
        check("over_drop_pulse", drop_pulse, 1);
        check("over_drop_count", drop_count, 1);
        for (int i = 0; i < 33; i++) begin
            send_word(16'h5000 + 16'(i));
            if (i == 0) check("over_pulse_single", drop_pulse, 0);
        end
        check("over_no_output", out_valid, 0);
        exp_q.push_back({1'b1, 16'h005A});
        send_word(16'h0001);
        send_word(16'h005A);
        wait_drain();
        check("over_drop_seen", drop_seen, 1);
        check("over_drop_count_end", drop_count, 1);
        check("over_pkt_count", pkt_count, 3);

        // Zero-length packet is dropped without leaving HDR.
        send_word(16'h0000);
        check("zero_drop_pulse", drop_pulse, 1);
        exp_q.push_back({1'b1, 16'h0051});
        send_word(16'h0001);
        send_word(16'h0051);
        wait_drain();
        check("zero_drop_count", drop_count, 2);
        check("zero_pkt_count", pkt_count, 4);

        // Random back-to-back packets with random stalls on both sides.
        rand_rdy = 1'b1;
        for (int p = 0; p < 100; p++) begin
            len = $urandom_range(1, 32);
            send_word(16'(len));
            for (int k = 0; k < len; k++) begin
                w = 16'($urandom_range(0, 65535));
                exp_q.push_back({(k == len - 1), w});
                send_word(w);
                if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
            end
        end
        rand_rdy = 1'b0;
        out_ready = 1'b1;
        wait_drain();
        check("rand_pkt_count", pkt_count, 104);
        check("rand_drop_count", drop_count, 2);

        // Reset in the middle of a packet.
        out_ready = 1'b0;
        send_word(16'h0005);
        send_word(16'h7001);
        send_word(16'h7002);
        #2;
        rst = 1'b0;
        #1;
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_out_data", out_data, 0);
        check("mid_rst_out_last", out_last, 0);
        check("mid_rst_in_ready", in_ready, 0);
        check("mid_rst_pkt_count", pkt_count, 0);
        check("mid_rst_drop_count", drop_count, 0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        exp_q.push_back({1'b1, 16'h00EE});
        send_word(16'h0001);
        send_word(16'h00EE);
        wait_drain();
        idle(5);
        check("after_rst_pkt_count", pkt_count, 1);
        check("after_rst_queue", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
